// File: rtl/trng_com_rx.sv
`default_nettype none
// ============================================================================
// Module   : trng_com_rx
// Purpose  : UART-style (8N1) receiver with a show-ahead byte FIFO and RTS pacing.
//            Define TRNG_COM_RX_PARITY_EN to switch the frame to 8E1 with o_parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module trng_com_rx #(
    parameter int CLK_DIV          = 16,
    parameter int FIFO_DEPTH_WIDTH = 2,
    parameter int RTS_MARGIN       = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_serial_data,
    input  logic       i_read,
    input  logic       i_clear_err,
    output logic [7:0] o_dat,
    output logic       o_valid,
    output logic       o_new_frame,
    output logic       o_serial_rts_n,
    output logic       o_frame_err,
`ifdef TRNG_COM_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_overrun
);
    localparam int c_cnt_w = $clog2(CLK_DIV);
    localparam int c_depth = 1 << FIFO_DEPTH_WIDTH;
    localparam logic [c_cnt_w-1:0]          c_half     = c_cnt_w'(CLK_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0]          c_full     = c_cnt_w'(CLK_DIV - 1);
    localparam logic [FIFO_DEPTH_WIDTH:0]   c_full_cnt = (FIFO_DEPTH_WIDTH + 1)'(c_depth);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_sync;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit_idx, w_idx_nxt;
    logic [7:0]           r_shreg, w_shreg_nxt;
    logic                 w_s_rx, w_tick;
    logic                 w_good, w_frame_set, w_par_set;

    logic [7:0]                  r_mem [c_depth];
    logic [FIFO_DEPTH_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_DEPTH_WIDTH:0]   r_count;
    logic                        w_pop, w_push, w_full, w_ovr_set;
    logic                        r_new_frame, r_rts_n, r_frame_err, r_overrun;

    assign w_s_rx = r_sync[1];
    assign w_tick = (r_cnt == '0);

`ifdef TRNG_COM_RX_PARITY_EN
    logic r_par, w_par_nxt, r_parity_err;
    assign o_parity_err = r_parity_err;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? r_cnt : r_cnt - 1'b1;
        w_idx_nxt   = r_bit_idx;
        w_shreg_nxt = r_shreg;
        w_good      = 1'b0;
        w_frame_set = 1'b0;
        w_par_set   = 1'b0;
`ifdef TRNG_COM_RX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_s_rx) begin
                    w_cnt_nxt   = c_half;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (!w_s_rx) begin
                        w_cnt_nxt   = c_full;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shreg_nxt = {w_s_rx, r_shreg[7:1]};
                    w_cnt_nxt   = c_full;
                    w_idx_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef TRNG_COM_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef TRNG_COM_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_par_nxt   = w_s_rx;
                    w_cnt_nxt   = c_full;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop-bit lets the next start edge follow immediately
                if (w_tick) begin
                    if (w_s_rx) begin
`ifdef TRNG_COM_RX_PARITY_EN
                        w_good    = ~(^{r_shreg, r_par});
                        w_par_set = ^{r_shreg, r_par};
`else
                        w_good    = 1'b1;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_set = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_s_rx) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= 2'b11;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
        end else begin
            r_sync    <= {r_sync[0], i_serial_data};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_idx_nxt;
            r_shreg   <= w_shreg_nxt;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_pop     = i_read & (r_count != '0);
    assign w_full    = (r_count == c_full_cnt);
    assign w_push    = w_good & (~w_full | w_pop);
    assign w_ovr_set = w_good & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < c_depth; i++) r_mem[i] <= 8'h00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_new_frame <= 1'b0;
            r_rts_n     <= 1'b1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shreg;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            r_new_frame <= w_push;
            r_rts_n     <= ((c_depth - int'(r_count)) <= RTS_MARGIN);
            if (w_frame_set)      r_frame_err <= 1'b1;
            else if (i_clear_err) r_frame_err <= 1'b0;
            if (w_ovr_set)        r_overrun <= 1'b1;
            else if (i_clear_err) r_overrun <= 1'b0;
        end
    end

`ifdef TRNG_COM_RX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
            if (w_par_set)        r_parity_err <= 1'b1;
            else if (i_clear_err) r_parity_err <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_par_set;
`endif

    assign o_dat          = r_mem[r_rd_ptr];
    assign o_valid        = (r_count != '0);
    assign o_new_frame    = r_new_frame;
    assign o_serial_rts_n = r_rts_n;
    assign o_frame_err    = r_frame_err;
    assign o_overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_trng_com_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_com_rx
// Purpose  : Directed, table-driven self-checking bench for trng_com_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_com_rx;
    localparam int CLK_DIV = 16;
`ifdef TRNG_COM_RX_PARITY_EN
    localparam int c_latency = 171;
`else
    localparam int c_latency = 155;
`endif

    logic       clk = 1'b0;
    logic       i_reset, i_serial_data, i_read, i_clear_err;
    logic [7:0] o_dat;
    logic       o_valid, o_new_frame, o_serial_rts_n, o_frame_err, o_overrun;
`ifdef TRNG_COM_RX_PARITY_EN
    logic       o_parity_err;
`endif

    int n_pass = 0, n_total = 0;
    int cyc = 0, nf_count = 0, nf_cyc = 0;

    typedef struct {
        logic [7:0] tx;
        logic       exp_ovr;
        logic       exp_rts_n;
    } ov_vec_t;

    trng_com_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH_WIDTH(2), .RTS_MARGIN(2)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_serial_data (i_serial_data),
        .i_read        (i_read),
        .i_clear_err   (i_clear_err),
        .o_dat         (o_dat),
        .o_valid       (o_valid),
        .o_new_frame   (o_new_frame),
        .o_serial_rts_n(o_serial_rts_n),
        .o_frame_err   (o_frame_err),
`ifdef TRNG_COM_RX_PARITY_EN
        .o_parity_err  (o_parity_err),
`endif
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (o_new_frame === 1'b1) begin
            nf_count++;
            nf_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line is left at the stop value on return
    task automatic send(input logic [7:0] d, input logic stop_v);
        i_serial_data = 1'b0;
        cyc_wait(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            i_serial_data = d[i];
            cyc_wait(CLK_DIV);
        end
`ifdef TRNG_COM_RX_PARITY_EN
        i_serial_data = ^d;
        cyc_wait(CLK_DIV);
`endif
        i_serial_data = stop_v;
        cyc_wait(CLK_DIV);
    endtask

    task automatic pop();
        i_read = 1'b1;
        cyc_wait(1);
        i_read = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_dat"}, 32'(o_dat), 32'h00);
        chk({tag, "_new_frame"}, 32'(o_new_frame), 32'd0);
        chk({tag, "_rts_n"}, 32'(o_serial_rts_n), 32'd1);
        chk({tag, "_frame_err"}, 32'(o_frame_err), 32'd0);
        chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
    endtask

    initial begin
        ov_vec_t    ov_tab[5];
        logic [7:0] b2b_exp[3];
        logic [7:0] pop_exp[4];
        logic [7:0] part;
        int         nf0, t0;

        ov_tab[0] = '{8'h11, 1'b0, 1'b0};
        ov_tab[1] = '{8'h22, 1'b0, 1'b1};
        ov_tab[2] = '{8'h33, 1'b0, 1'b1};
        ov_tab[3] = '{8'h44, 1'b0, 1'b1};
        ov_tab[4] = '{8'h99, 1'b1, 1'b1};
        b2b_exp   = '{8'h00, 8'hFF, 8'h55};
        pop_exp   = '{8'h22, 8'h33, 8'h44, 8'h77};

        i_reset = 1'b1; i_serial_data = 1'b1; i_read = 1'b0; i_clear_err = 1'b0;
        cyc_wait(3);
        chk_reset_state("rst");
        i_reset = 1'b0;
        cyc_wait(3);
        chk("rts_after_rst", 32'(o_serial_rts_n), 32'd0);

        // Single frame, latency and pop
        nf0 = nf_count;
        t0  = cyc;
        send(8'hA5, 1'b1);
        cyc_wait(10);
        chk("a5_latency", 32'(nf_cyc - t0), 32'(c_latency));
        chk("a5_pulses", 32'(nf_count - nf0), 32'd1);
        chk("a5_valid", 32'(o_valid), 32'd1);
        chk("a5_dat", 32'(o_dat), 32'hA5);
        pop();
        chk("a5_pop_valid", 32'(o_valid), 32'd0);

        // Back-to-back frames, no idle gap
        send(8'h00, 1'b1);
        chk("b2b_rts_1", 32'(o_serial_rts_n), 32'd0);
        send(8'hFF, 1'b1);
        chk("b2b_rts_2", 32'(o_serial_rts_n), 32'd1);
        send(8'h55, 1'b1);
        cyc_wait(5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_valid_%0d", i), 32'(o_valid), 32'd1);
            chk($sformatf("b2b_dat_%0d", i), 32'(o_dat), 32'(b2b_exp[i]));
            pop();
        end
        chk("b2b_empty", 32'(o_valid), 32'd0);

        // Fill past depth: fifth byte overruns
        nf0 = nf_count;
        for (int i = 0; i < 5; i++) begin
            send(ov_tab[i].tx, 1'b1);
            cyc_wait(1);
            chk($sformatf("ov_flag_%0d", i), 32'(o_overrun), 32'(ov_tab[i].exp_ovr));
            chk($sformatf("ov_rts_%0d", i), 32'(o_serial_rts_n), 32'(ov_tab[i].exp_rts_n));
        end
        chk("ov_pulses", 32'(nf_count - nf0), 32'd4);
        i_clear_err = 1'b1;
        cyc_wait(1);
        i_clear_err = 1'b0;
        chk("ov_cleared", 32'(o_overrun), 32'd0);
        chk("ov_head", 32'(o_dat), 32'h11);

        // Pop coincident with the stop tick while full: no overrun
        nf0 = nf_count;
        fork
            send(8'h77, 1'b1);
            begin
                repeat (c_latency - 1) @(posedge clk);
                #1 i_read = 1'b1;
                @(posedge clk);
                #1 i_read = 1'b0;
            end
        join
        cyc_wait(2);
        chk("full_pp_ovr", 32'(o_overrun), 32'd0);
        chk("full_pp_pulse", 32'(nf_count - nf0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_pop_dat_%0d", i), 32'(o_dat), 32'(pop_exp[i]));
            pop();
        end
        chk("full_pop_empty", 32'(o_valid), 32'd0);
        pop();
        chk("empty_pop_ignored", 32'(o_valid), 32'd0);

        // Short low glitch
        nf0 = nf_count;
        i_serial_data = 1'b0;
        cyc_wait(3);
        i_serial_data = 1'b1;
        cyc_wait(30);
        chk("glitch_valid", 32'(o_valid), 32'd0);
        chk("glitch_pulses", 32'(nf_count - nf0), 32'd0);
        chk("glitch_ferr", 32'(o_frame_err), 32'd0);
        chk("glitch_ovr", 32'(o_overrun), 32'd0);

        // Framing error followed by a long break
        send(8'h3C, 1'b0);
        cyc_wait(24);
        i_serial_data = 1'b1;
        cyc_wait(20);
        chk("ferr_valid", 32'(o_valid), 32'd0);
        chk("ferr_pulses", 32'(nf_count - nf0), 32'd0);
        chk("ferr_flag", 32'(o_frame_err), 32'd1);
        send(8'h81, 1'b1);
        cyc_wait(2);
        chk("ferr_next_valid", 32'(o_valid), 32'd1);
        chk("ferr_next_dat", 32'(o_dat), 32'h81);
        chk("ferr_sticky", 32'(o_frame_err), 32'd1);

        // Reset in the middle of the fourth data bit
        part = 8'h5A;
        i_serial_data = 1'b0;
        cyc_wait(CLK_DIV);
        for (int i = 0; i < 3; i++) begin
            i_serial_data = part[i];
            cyc_wait(CLK_DIV);
        end
        i_serial_data = part[3];
        cyc_wait(CLK_DIV / 2);
        i_reset = 1'b1;
        cyc_wait(2);
        chk_reset_state("midrst");
        i_reset = 1'b0;
        i_serial_data = 1'b1;
        cyc_wait(20);
        send(8'h12, 1'b1);
        cyc_wait(2);
        chk("post_rst_valid", 32'(o_valid), 32'd1);
        chk("post_rst_dat", 32'(o_dat), 32'h12);
        chk("post_rst_ferr", 32'(o_frame_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trng_com_rx.md
Name: trng_com_rx

Overview:
Serial (UART-style, 8N1) receiver that forms the host-to-board end of the trng_com link. It synchronises and deserialises the incoming serial line into bytes and buffers them in a small show-ahead FIFO. It paces the host through an active-low RTS output. Downstream control logic (commands, reseed, dump triggers) consumes bytes with a valid/read handshake.

Parameters:
CLK_DIV, 16, i_clk cycles per serial bit; integer >= 4.
FIFO_DEPTH_WIDTH, 2, log2 of receive FIFO depth (default 4 entries).
RTS_MARGIN, 2, o_serial_rts_n goes high when free FIFO entries <= RTS_MARGIN; range 1..depth-1.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_serial_data  in  1  asynchronous serial line, idle high
i_read  in  1  pop head byte; effective only when o_valid=1
i_clear_err  in  1  clears sticky error flags
o_dat  out  8  FIFO head byte, meaningful when o_valid=1
o_valid  out  1  FIFO non-empty
o_new_frame  out  1  1-cycle pulse when a good byte is pushed
o_serial_rts_n  out  1  0 = host may send; 1 = stop sending
o_frame_err  out  1  sticky: stop bit sampled low
o_overrun  out  1  sticky: good byte dropped because FIFO full

Behaviour:
- Reset values: o_valid=0, o_dat=8'h00, o_new_frame=0, o_serial_rts_n=1 during reset then 0 from the first cycle after, o_frame_err=0, o_overrun=0, FSM=IDLE, FIFO empty, synchroniser flops=1.
- Input: 2-flop synchroniser; FSM uses the synchronised s_rx (2-cycle line latency).
- Bit counter width $clog2(CLK_DIV); counts down; "tick" = counter==0.
- FSM states:
  - IDLE: on s_rx==0, load CLK_DIV/2-1 and go to START.
  - START: on tick, if s_rx==0 load CLK_DIV-1, clear bit index, go to DATA; else (glitch) go to IDLE.
  - DATA: on tick, shift in LSB first (shreg <= {s_rx, shreg[7:1]}) and reload CLK_DIV-1. After the 8th bit go to STOP.
  - STOP: on tick, if s_rx==1 push the byte and go to IDLE. If s_rx==0, set o_frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until s_rx==1 (break/garbage), then go to IDLE.
- Return to IDLE at mid-stop-bit permits back-to-back frames with no extra idle time.
- Push:
  - A good byte with FIFO not full is written, and o_new_frame pulses in the cycle after the stop tick. o_valid rises that same cycle, so byte latency is 1 cycle after the stop tick.
  - A good byte with FIFO full is dropped, the FIFO is unchanged, and o_overrun is set.
  - Push and pop in the same cycle are both honoured and the count is unchanged; allowed even when full (the pop frees the slot first, no overrun).
- Pop: i_read & o_valid advances the head; o_dat shows the new head next cycle. i_read with o_valid=0 is ignored.
- o_serial_rts_n is registered: 1 when (depth - count) <= RTS_MARGIN, else 0. It updates the cycle after the count changes.
- Sticky flags clear on i_clear_err. A set event in the same cycle wins over the clear.
- Reset mid-frame aborts the frame, empties the FIFO and returns to IDLE. A line still low after reset is treated as a start bit.

Optional Feature:
TRNG_COM_RX_PARITY_EN:
- Defined: frame is 8E1. A PARITY state is inserted between DATA and STOP, sampled on tick. The stop tick pushes only if stop==1 and XOR(data, parity)==0. On a parity mismatch with a good stop bit, the byte is discarded, sticky output o_parity_err (1 bit, reset 0, cleared by i_clear_err) is set, and the FSM goes to IDLE.
- Undefined: no PARITY state and no o_parity_err port; the frame is 8N1.

Test Plan:
- CLK_DIV=16; send 8'hA5 (8N1), then idle. Required: o_valid rises with o_dat=8'hA5 and o_new_frame pulses once, 1 cycle after the stop tick. i_read=1 for one cycle -> o_valid=0.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap, i_read held 0. Required: FIFO holds 3 entries in order; o_serial_rts_n=1 after the 2nd byte (free=2 <= RTS_MARGIN).
- 5 bytes with i_read=0 (depth 4). Required: 4 bytes stored; 5th dropped; o_overrun=1; i_clear_err -> o_overrun=0; pops return bytes 1..4.
- Frame 8'h3C with the stop bit driven low, line held low 40 cycles then high. Required: nothing pushed; o_frame_err=1; next valid frame 8'h81 is received correctly.
- 3-cycle low glitch on an idle line. Required: START aborts to IDLE; no push; no error flags.
- Assert i_reset during the 4th data bit. Required: all outputs return to reset values. After reset, a clean frame 8'h12 is received.
